// File: rtl/cs_pkg.sv
// Shared defaults and state encoding for the CS sliding-window sequencer.
package cs_pkg;
  localparam int WIN_DEF = 9;
  localparam int X_W_DEF = 8;
  localparam int Y_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } cs_state_e;
endpackage

// File: rtl/cs_seq_if.sv
// Sample-in / result-out handshake bundle between the sequencer and its neighbours.
interface cs_seq_if
  import cs_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
);
  logic           in_valid;
  logic           in_ready;
  logic [X_W-1:0] x_in;
  logic           sof;
  logic           eof;
  logic [Y_W-1:0] y_out;
  logic           y_valid;
  logic           y_ready;

  modport master (
    output in_valid, x_in, sof, eof, y_ready,
    input  in_ready, y_out, y_valid
  );

  modport slave (
    input  in_valid, x_in, sof, eof, y_ready,
    output in_ready, y_out, y_valid
  );
endinterface

// File: rtl/cs_seq.sv
// Frame sequencer for an external WIN-tap sliding-window datapath: gates shifts,
// tracks window fill, and hands results downstream with backpressure.
module cs_seq
  import cs_pkg::*;
#(
  parameter int WIN = WIN_DEF,
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  cs_seq_if.slave        bus,
  output logic           dp_shift,
  output logic           dp_clear,
  output logic [X_W-1:0] dp_x,
  input  logic [Y_W-1:0] y_in,
  output logic           frame_done,
  output logic           short_frame,
  output logic           abort,
  output logic           drop,
  output logic [1:0]     state,
  output logic [15:0]    out_cnt
);
  localparam int FILL_W = $clog2(WIN + 1);
  localparam logic [FILL_W-1:0] WIN_F = FILL_W'(WIN);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state_q;
  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_nxt;
  logic              y_vld;
  logic              accept;
  logic              active;
  logic              fill_full;
  logic              y_set;
  logic              y_take;

  assign bus.in_ready = (!y_vld || bus.y_ready) && (state_q != ST_DONE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign active       = (state_q == ST_FILL) || (state_q == ST_RUN);

  // Outside a frame only a sof sample may enter the window; others are dropped.
  assign dp_shift = accept && (active || ((state_q == ST_IDLE) && bus.sof));
  assign dp_clear = dp_shift && bus.sof;
  assign dp_x     = bus.x_in;

  assign bus.y_out   = y_in;
  assign bus.y_valid = y_vld;
  assign y_take      = y_vld && bus.y_ready;
  assign state       = state_q;

  always_comb begin
    fill_nxt = fill_cnt;
    if (bus.sof)
      fill_nxt = FILL_W'(1);
    else if (fill_cnt != WIN_F)
      fill_nxt = fill_cnt + FILL_W'(1);
  end

  assign fill_full = (fill_nxt == WIN_F);
  assign y_set     = dp_shift && fill_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      fill_cnt    <= '0;
      out_cnt     <= '0;
      y_vld       <= 1'b0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      abort       <= 1'b0;
      drop        <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      abort       <= 1'b0;
      drop        <= 1'b0;

      // A restart discards any result still waiting for the sink.
      if (y_set)
        y_vld <= 1'b1;
      else if (y_take || dp_clear)
        y_vld <= 1'b0;

      if (dp_clear)
        out_cnt <= '0;
      else if (y_take && (out_cnt != 16'hFFFF))
        out_cnt <= out_cnt + 16'd1;

      if (dp_shift) begin
        fill_cnt    <= fill_nxt;
        abort       <= bus.sof && active;
        short_frame <= bus.eof && !fill_full;
        if (bus.eof)
          state_q <= fill_full ? ST_DONE : ST_IDLE;
        else
          state_q <= fill_full ? ST_RUN : ST_FILL;
      end else if (accept && (state_q == ST_IDLE)) begin
        drop <= 1'b1;
      end else if ((state_q == ST_DONE) && y_take) begin
        state_q    <= ST_IDLE;
        frame_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cs_seq.sv
// Directed bench for cs_seq with a sliding-sum datapath model driving y_in.
module tb_cs_seq;
  import cs_pkg::*;

  localparam int WIN = 9;
  localparam int X_W = 8;
  localparam int Y_W = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           dp_shift, dp_clear;
  logic [X_W-1:0] dp_x;
  logic [Y_W-1:0] y_in = '0;
  logic           frame_done, short_frame, abort, drop;
  logic [1:0]     state;
  logic [15:0]    out_cnt;

  always #5 clk = ~clk;

  cs_seq_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  cs_seq #(.WIN(WIN), .X_W(X_W), .Y_W(Y_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dp_shift    (dp_shift),
    .dp_clear    (dp_clear),
    .dp_x        (dp_x),
    .y_in        (y_in),
    .frame_done  (frame_done),
    .short_frame (short_frame),
    .abort       (abort),
    .drop        (drop),
    .state       (state),
    .out_cnt     (out_cnt)
  );

  // Datapath stand-in: y_in is the sum of the last WIN shifted samples.
  logic [X_W-1:0] dwin [WIN];
  initial for (int i = 0; i < WIN; i++) dwin[i] = '0;

  always @(posedge clk) begin : dp_model
    logic [X_W-1:0] nw [WIN];
    int acc;
    if (dp_shift) begin
      for (int i = WIN - 1; i > 0; i--) nw[i] = dp_clear ? '0 : dwin[i-1];
      nw[0] = dp_x;
      acc = 0;
      for (int i = 0; i < WIN; i++) acc += int'(nw[i]);
      for (int i = 0; i < WIN; i++) dwin[i] <= nw[i];
      y_in <= Y_W'(acc);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  int cyc = 0, n_shift = 0, n_res = 0, n_fd = 0, n_short = 0, n_abort = 0, n_drop = 0, n_yv = 0;
  logic prev_yv = 1'b0;
  int res_q[$];
  int shift_cyc_q[$];
  int rise_cyc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (dp_shift) begin n_shift++; shift_cyc_q.push_back(cyc); end
    if (bus.y_valid && bus.y_ready) begin n_res++; res_q.push_back(int'(bus.y_out)); end
    if (bus.y_valid) n_yv++;
    if (bus.y_valid && !prev_yv) rise_cyc_q.push_back(cyc);
    prev_yv = bus.y_valid;
    if (frame_done) n_fd++;
    if (short_frame) n_short++;
    if (abort) n_abort++;
    if (drop) n_drop++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int res_at(input int i);
    return (res_q.size() > i) ? res_q[i] : -1;
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.sof = 1'b0;
    bus.eof = 1'b0;
  endtask

  // Present one sample and return just after the edge that accepts it.
  task automatic send(input logic [X_W-1:0] x, input logic s, input logic e);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.x_in = x;
    bus.sof = s;
    bus.eof = e;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [X_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) send(base + X_W'(i), i == 0, i == n - 1);
    idle();
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (state != 2'd0 && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) chk("idle_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    res_q.delete();
    shift_cyc_q.delete();
    rise_cyc_q.delete();
  endtask

  logic [Y_W-1:0] hold;
  int s0, r0, f0, sh0, a0, d0, y0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle();
    bus.x_in = '0;
    bus.y_ready = 1'b1;

    // Reset held two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_pulses", 32'({frame_done, short_frame, abort, drop}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // 12-sample frame, sink always ready
    clear_logs();
    s0 = n_shift; r0 = n_res; f0 = n_fd;
    send_frame(8'h10, 12);
    wait_idle();
    chk("f12_shifts", 32'(n_shift - s0), 32'd12);
    chk("f12_results", 32'(n_res - r0), 32'd4);
    chk("f12_res0", 32'(res_at(0)), 32'd180);
    chk("f12_res1", 32'(res_at(1)), 32'd189);
    chk("f12_res2", 32'(res_at(2)), 32'd198);
    chk("f12_res3", 32'(res_at(3)), 32'd207);
    chk("f12_first_yv", 32'((rise_cyc_q.size() > 0 && shift_cyc_q.size() > 8) ?
                            rise_cyc_q[0] - shift_cyc_q[8] : -1), 32'd1);
    chk("f12_frame_done", 32'(n_fd - f0), 32'd1);
    chk("f12_out_cnt", 32'(out_cnt), 32'd4);
    chk("f12_state", 32'(state), 32'd0);

    // Same frame, sink stalls three cycles on the first result
    clear_logs();
    s0 = n_shift; r0 = n_res; f0 = n_fd;
    bus.y_ready = 1'b0;
    fork
      send_frame(8'h10, 12);
      begin
        int t = 0;
        while (!bus.y_valid && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("stall_timeout", 32'(t), 32'd0);
        hold = bus.y_out;
        for (int i = 0; i < 3; i++) begin
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
          chk("stall_dp_shift", 32'(dp_shift), 32'd0);
          chk("stall_y_out", 32'(bus.y_out), 32'd180);
          @(negedge clk);
        end
        @(posedge clk); #1;
        bus.y_ready = 1'b1;
      end
    join
    wait_idle();
    chk("stall_hold_val", 32'(hold), 32'd180);
    chk("stall_shifts", 32'(n_shift - s0), 32'd12);
    chk("stall_results", 32'(n_res - r0), 32'd4);
    chk("stall_res3", 32'(res_at(3)), 32'd207);
    chk("stall_frame_done", 32'(n_fd - f0), 32'd1);

    // Short frame of 5 samples
    r0 = n_res; sh0 = n_short; y0 = n_yv;
    send_frame(8'h30, 5);
    repeat (3) @(posedge clk); #1;
    chk("short_y_valid_cycles", 32'(n_yv - y0), 32'd0);
    chk("short_results", 32'(n_res - r0), 32'd0);
    chk("short_pulse", 32'(n_short - sh0), 32'd1);
    chk("short_state", 32'(state), 32'd0);

    // sof arrives as the 11th sample of a running frame
    r0 = n_res; a0 = n_abort;
    for (int i = 0; i < 10; i++) send(8'h20 + 8'(i), i == 0, 1'b0);
    bus.in_valid = 1'b1; bus.x_in = 8'h40; bus.sof = 1'b1; bus.eof = 1'b0;
    @(negedge clk);
    chk("abort_dp_shift", 32'(dp_shift), 32'd1);
    chk("abort_dp_clear", 32'(dp_clear), 32'd1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_fill_cnt", 32'(dut.fill_cnt), 32'd1);
    chk("abort_state", 32'(state), 32'd1);
    chk("abort_out_cnt", 32'(out_cnt), 32'd0);
    chk("abort_y_valid", 32'(bus.y_valid), 32'd0);
    @(posedge clk); #1;
    chk("abort_results", 32'(n_res - r0), 32'd2);
    chk("abort_count", 32'(n_abort - a0), 32'd1);
    send(8'h41, 1'b0, 1'b1);
    idle();
    wait_idle();

    // Non-sof sample while idle
    s0 = n_shift; d0 = n_drop;
    bus.in_valid = 1'b1; bus.x_in = 8'h55; bus.sof = 1'b0; bus.eof = 1'b0;
    @(negedge clk);
    chk("drop_dp_shift", 32'(dp_shift), 32'd0);
    chk("drop_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("drop_pulse", 32'(drop), 32'd1);
    chk("drop_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    chk("drop_count", 32'(n_drop - d0), 32'd1);
    chk("drop_no_shift", 32'(n_shift - s0), 32'd0);

    // sof and eof on the same sample
    sh0 = n_short;
    bus.in_valid = 1'b1; bus.x_in = 8'h66; bus.sof = 1'b1; bus.eof = 1'b1;
    @(negedge clk);
    chk("one_dp_clear", 32'(dp_clear), 32'd1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("one_short", 32'(short_frame), 32'd1);
    chk("one_state", 32'(state), 32'd0);
    chk("one_y_valid", 32'(bus.y_valid), 32'd0);
    @(posedge clk); #1;

    // Frame of exactly WIN samples gives one result
    clear_logs();
    r0 = n_res; f0 = n_fd;
    send_frame(8'h01, WIN);
    wait_idle();
    chk("win_results", 32'(n_res - r0), 32'd1);
    chk("win_res0", 32'(res_at(0)), 32'd45);
    chk("win_frame_done", 32'(n_fd - f0), 32'd1);
    chk("win_out_cnt", 32'(out_cnt), 32'd1);

    // Reset in the middle of a frame
    a0 = n_abort; f0 = n_fd;
    for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), i == 0, 1'b0);
    idle();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_fill_cnt", 32'(dut.fill_cnt), 32'd0);
    chk("mrst_out_cnt", 32'(out_cnt), 32'd0);
    chk("mrst_no_abort", 32'(n_abort - a0), 32'd0);
    chk("mrst_no_frame_done", 32'(n_fd - f0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cs_seq.md
CS_SEQ -- requirements
Module: cs_seq

Interface
REQ-001 SHALL provide parameter WIN, default 9, meaning samples per sliding window of the CS datapath.
REQ-002 SHALL provide parameter X_W, default 8, meaning input sample width.
REQ-003 SHALL provide parameter Y_W, default 10, meaning datapath result width.
REQ-004 SHALL provide port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL provide port reset  input  1  synchronous active-low reset.
REQ-006 SHALL provide port in_valid  input  1  upstream sample valid.
REQ-007 SHALL provide port in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-008 SHALL provide port x_in  input  X_W  upstream sample.
REQ-009 SHALL provide port sof / eof  input  1 each  first / last sample of frame, qualified by accept.
REQ-010 SHALL provide port dp_shift  output  1  advance datapath window by dp_x.
REQ-011 SHALL provide port dp_clear  output  1  discard datapath window contents; same cycle as dp_shift.
REQ-012 SHALL provide port dp_x  output  X_W  equals x_in combinationally.
REQ-013 SHALL provide port y_in  input  Y_W  datapath result, valid the cycle after dp_shift, stable while dp_shift=0.
REQ-014 SHALL provide ports y_out  output  Y_W  (=y_in), y_valid  output  1, y_ready  input  1  downstream handshake.
REQ-015 SHALL provide ports frame_done, short_frame, abort, drop  output  1 each  single-cycle status pulses.
REQ-016 SHALL provide ports state  output  2  and out_cnt  output  16  (results delivered in current frame).

Function
REQ-017 SHALL implement states IDLE, FILL, RUN, DONE.
REQ-018 Accept SHALL be in_valid && in_ready; dp_shift SHALL equal accept in FILL/RUN, or accept && sof in IDLE.
REQ-019 in_ready SHALL equal (!y_valid || y_ready) && state != DONE.
REQ-020 fill_cnt (0..WIN) SHALL increment per shift, saturate at WIN, load 1 on sof shift.
REQ-021 IDLE: sof accept -> FILL, dp_clear=1, fill_cnt=1, out_cnt=0; non-sof accept -> sample discarded, drop pulse, no dp_shift.
REQ-022 FILL -> RUN on the shift making fill_cnt=WIN; that shift and every RUN shift SHALL set y_valid next cycle.
REQ-023 y_valid SHALL clear on y_valid && y_ready with no new qualifying shift, and hold (y_out stable) otherwise.
REQ-024 out_cnt SHALL increment on y_valid && y_ready, saturating at 0xFFFF.
REQ-025 eof accept in FILL (fill_cnt<WIN after shift) SHALL pulse short_frame, -> IDLE, no y_valid.
REQ-026 eof accept in RUN SHALL -> DONE; DONE SHALL -> IDLE with frame_done pulse on final y_valid && y_ready.
REQ-027 sof accept in FILL/RUN SHALL pulse abort, restart per REQ-021 (dp_clear, -> FILL), and drop any pending y_valid.
REQ-028 sof && eof on one accept SHALL be a 1-sample frame: dp_clear, short_frame pulse, end in IDLE.
REQ-029 A frame of N>=WIN samples SHALL yield exactly N-WIN+1 results.

Reset
REQ-030 While reset=0 at a rising edge: state=IDLE, fill_cnt=0, out_cnt=0, y_valid=0, all pulses 0; in_ready=1 after release.
REQ-031 Reset mid-frame SHALL discard the frame with no frame_done/abort pulse.

Structure
REQ-032 Package cs_pkg SHALL hold WIN, X_W, Y_W defaults and the 2-bit state enum (IDLE=0, FILL=1, RUN=2, DONE=3).
REQ-033 No sub-module; FSM and counters inline in cs_seq; datapath instantiated outside.

Verification
REQ-034 reset=0 two cycles -> state=0, y_valid=0, out_cnt=0; in_ready=1 after release.
REQ-035 sof+12 samples 0x10..0x1B back-to-back, eof on last, y_ready=1 -> 12 dp_shift, first y_valid cycle after 9th accept, 4 results, frame_done, out_cnt=4.
REQ-036 As REQ-035 with y_ready=0 for 3 cycles at first y_valid -> in_ready=0, dp_shift=0, y_out unchanged 3 cycles, total still 4.
REQ-037 sof+5 samples with eof -> no y_valid, short_frame once, state IDLE.
REQ-038 sof at 11th sample of a running frame -> abort, dp_clear, fill_cnt=1, state FILL, out_cnt=0.
REQ-039 x_in=0x55 in IDLE without sof -> drop pulse, dp_shift=0, state IDLE.
